// File: rtl/nibble_stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_stepper_pkg
// Description : FSM encoding, step directions and wrap classification shared
//               by the nibble stepper.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_stepper_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_hold    = 2'd1;
    localparam logic [1:0] c_st_repeat  = 2'd2;
    localparam logic [1:0] c_st_lockout = 2'd3;

    localparam logic c_dir_up = 1'b1;
    localparam logic c_dir_dn = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = c_st_idle,
        ST_HOLD    = c_st_hold,
        ST_REPEAT  = c_st_repeat,
        ST_LOCKOUT = c_st_lockout
    } state_t;

    // Unsigned wraps at 15<->0, the two's-complement view at +7<->-8.
    function automatic logic is_wrap(input logic [3:0] v, input logic up,
                                     input logic signed_mode);
        logic [3:0] w_edge;
        w_edge = signed_mode ? (up ? 4'd7 : 4'd8) : (up ? 4'd15 : 4'd0);
        return v == w_edge;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_stepper_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizes an active-low button, debounces it and emits a
//               single-cycle press pulse on each accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_pressed;
    logic               w_flip;

    assign w_pressed = ~r_sync2;
    assign w_flip    = (w_pressed != r_level) && (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1));

    // Synchronizer idles high so a held button reads as released after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
            r_press <= w_flip && !r_level;
            if (w_pressed == r_level || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/nibble_stepper.sv
`default_nettype none
// ============================================================================
// Module      : nibble_stepper
// Description : Pushbutton up/down nibble stepper with auto-repeat, signed
//               mode select and wrap-crossing pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_stepper
    import nibble_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    input  logic       sw_signed,
    output logic [3:0] value,
    output logic       negselect,
    output logic       wrap
);

    localparam int c_timer_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_timer_w   = $clog2(c_timer_max + 1);

    logic                 w_up_level, w_up_press;
    logic                 w_dn_level, w_dn_press;
    logic                 r_sw_sync1, r_sw_sync2, r_negselect;
    state_t               r_state, w_state_nxt;
    logic                 r_dir, w_dir_nxt;
    logic [c_timer_w-1:0] r_timer, w_load_val;
    logic                 w_load;
    logic                 w_step, w_step_up;
    logic                 w_own, w_other;
    logic [3:0]           r_value;
    logic                 r_wrap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_n (btn_up_n),
        .level (w_up_level),
        .press (w_up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_n (btn_dn_n),
        .level (w_dn_level),
        .press (w_dn_press)
    );

    assign w_own   = (r_dir == c_dir_up) ? w_up_level : w_dn_level;
    assign w_other = (r_dir == c_dir_up) ? w_dn_level : w_up_level;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        w_step_up   = r_dir;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_up_press && w_dn_press) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (w_up_press || w_dn_press) begin
                    w_step      = 1'b1;
                    w_step_up   = w_up_press ? c_dir_up : c_dir_dn;
                    w_dir_nxt   = w_step_up;
                    w_load      = 1'b1;
                    w_load_val  = c_timer_w'(REPEAT_DELAY - 1);
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A conflicting press or release wins over a due repeat step.
                if (w_other) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (!w_own) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == '0) begin
                    w_step      = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = c_timer_w'(REPEAT_PERIOD - 1);
                    w_state_nxt = ST_REPEAT;
                end
            end
            ST_LOCKOUT: begin
                if (!w_up_level && !w_dn_level) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dir       <= c_dir_up;
            r_timer     <= '0;
            r_value     <= 4'd0;
            r_wrap      <= 1'b0;
            r_sw_sync1  <= 1'b0;
            r_sw_sync2  <= 1'b0;
            r_negselect <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_sw_sync1  <= sw_signed;
            r_sw_sync2  <= r_sw_sync1;
            r_negselect <= r_sw_sync2;
            if (w_load) begin
                r_timer <= w_load_val;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end
            r_wrap <= w_step && is_wrap(r_value, w_step_up, r_negselect);
            if (w_step) begin
                r_value <= w_step_up ? r_value + 4'd1 : r_value - 4'd1;
            end
        end
    end

    assign value     = r_value;
    assign negselect = r_negselect;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire
